seq_divider16: RTL and testbench



---
 rtl/seq_divider16.sv | 111 +++++++++++
 tb/tb_seq_divider16.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider16.sv
// seq_divider16: unsigned restoring divider, one quotient bit per clock.
// A (with one guard bit) and Q form a single shift register, and M holds
// the divisor. A start/done handshake wraps the datapath.
// Divide-by-zero skips the iterations and reports all-ones / dividend.
module seq_divider16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             re,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r, state_nx;
   logic [WIDTH:0]   a_r, a_sh, a_nx, diff;
   logic [WIDTH-1:0] q_r, q_nx;
   logic [WIDTH:0]   m_r;
   logic [CW-1:0]    count_r;
   logic             last_iter;

   assign busy      = (state_r != IDLE);
   assign done      = (state_r == DONE);
   assign last_iter = (count_r == CW'(1));

   // One restoring step: shift {A,Q} left, trial-subtract M, and keep or restore A.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      a_sh = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
      diff = a_sh - m_r;
      a_nx = a_sh;
      q_nx = {q_r[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH]) begin
         a_nx = diff;
         q_nx = {q_r[WIDTH-2:0], 1'b1};
      end
   end

   // Next-state logic. A zero divisor goes straight to DONE.
   always_comb begin
      state_nx = state_r;
      unique case (state_r)
         IDLE:    if (start) state_nx = (divisor == '0) ? DONE : CALC;
         CALC:    if (last_iter) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge re) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!re) state_r <= IDLE;
      else     state_r <= state_nx;
   end

   // Datapath and result registers. Results load only on the edge that enters DONE.
   always_ff @(posedge clk or negedge re) begin
      if (!re) begin
         a_r         <= '0;
         q_r         <= '0;
         m_r         <= '0;
         count_r     <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state_r)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     a_r     <= '0;
                     q_r     <= dividend;
                     m_r     <= {1'b0, divisor};
                     count_r <= CW'(WIDTH);
                  end
               end
            end
            CALC: begin
               a_r     <= a_nx;
               q_r     <= q_nx;
               count_r <= count_r - CW'(1);
               if (last_iter) begin
                  quotient    <= q_nx;
                  remainder   <= a_nx[WIDTH-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider16.sv
// tb_seq_divider16: directed tests plus random pairs checked against / and %.
// Edge 0 is the edge right before start is raised. The divider samples start
// on edge 1, and done is expected after edge 17 (edge 1 for divide-by-zero).
module tb_seq_divider16;

   logic        clk;
   logic        re;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_divider16 #(.WIDTH(16)) dut (
      .clk         (clk),
      .re          (re),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start one division just after edge 0 and check its latency, results and return to idle.
   task automatic run_div(input string tag, input logic [15:0] dd, input logic [15:0] dv,
                          input logic [15:0] exp_q, input logic [15:0] exp_r,
                          input logic exp_dz, input int exp_lat);
      int lat;
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " busy"}, busy, 1);
      lat = 1;
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " quotient"}, quotient, exp_q);
      check({tag, " remainder"}, remainder, exp_r);
      check({tag, " dz"}, div_by_zero, exp_dz);
      tick();
      check({tag, " done drop"}, done, 0);
      check({tag, " idle"}, busy, 0);
   endtask

   initial begin
      int pulses;
      int done_edge;
      logic [15:0] cap_q, cap_r;
      logic [15:0] rd, rv;
      int          d_edges[$];

      re       = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      tick();
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset dz", div_by_zero, 0);
      re = 1'b1;
      tick();

      // Basic function and operand extremes.
      run_div("100/7",     16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17);
      run_div("ffff/1",    16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
      run_div("ffff/ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17);
      run_div("5/9",       16'd5,    16'd9,    16'd0,    16'd5,    1'b0, 17);
      run_div("0/3",       16'd0,    16'd3,    16'd0,    16'd0,    1'b0, 17);

      // Divide by zero, then a normal run that clears the flag.
      run_div("1234/0",    16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 1);
      run_div("8/2",       16'd8,    16'd2,    16'd4,    16'd0,    1'b0, 17);

      // A second start during CALC must be ignored.
      dividend = 16'd1000;
      divisor  = 16'd3;
      start    = 1'b1;
      tick();                                   // edge 1: accepted
      start = 1'b0;
      tick(); tick(); tick();                   // edges 2..4
      dividend = 16'd50;
      divisor  = 16'd5;
      start    = 1'b1;
      tick();                                   // edge 5: must be ignored
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      pulses    = 0;
      done_edge = 0;
      cap_q     = '0;
      cap_r     = '0;
      for (int e = 6; e <= 30; e++) begin
         tick();
         if (done) begin
            pulses++;
            done_edge = e;
            cap_q     = quotient;
            cap_r     = remainder;
         end
      end
      check("ignore pulses", pulses, 1);
      check("ignore done edge", done_edge, 17);
      check("ignore quotient", cap_q, 16'd333);
      check("ignore remainder", cap_r, 16'd1);

      // Asynchronous reset in mid-calculation.
      dividend = 16'd60000;
      divisor  = 16'd7;
      start    = 1'b1;
      tick();                                   // edge 1
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();       // edges 2..8
      #3;
      re = 1'b0;
      #1;
      check("async rst busy", busy, 0);
      check("async rst done", done, 0);
      check("async rst quotient", quotient, 0);
      check("async rst remainder", remainder, 0);
      check("async rst dz", div_by_zero, 0);
      tick();
      tick();
      re = 1'b1;
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (done) pulses++;
      end
      check("no done after rst", pulses, 0);
      run_div("9/4", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 17);

      // start held high: results back-to-back every 18 cycles.
      dividend = 16'd77;
      divisor  = 16'd10;
      start    = 1'b1;
      for (int e = 1; e <= 60; e++) begin
         tick();
         if (done) begin
            d_edges.push_back(e);
            check("b2b quotient", quotient, 16'd7);
            check("b2b remainder", remainder, 16'd7);
         end
      end
      start = 1'b0;
      check("b2b pulse count", d_edges.size(), 3);
      if (d_edges.size() == 3) begin
         check("b2b edge 1", d_edges[0], 17);
         check("b2b edge 2", d_edges[1], 35);
         check("b2b edge 3", d_edges[2], 53);
      end
      for (int i = 0; i < 20; i++) tick();
      check("b2b drained", busy, 0);

      // Random operand pairs against the language's own / and %.
      for (int n = 0; n < 1000; n++) begin
         rd = 16'($urandom);
         case ($urandom_range(0, 9))
            0:       rv = 16'd0;
            1:       rv = 16'($urandom_range(1, 15));
            default: rv = 16'($urandom);
         endcase
         if (rv == 16'd0) run_div("rand", rd, rv, 16'hFFFF, rd, 1'b1, 1);
         else             run_div("rand", rd, rv, rd / rv, rd % rv, 1'b0, 17);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
